gray_check: RTL and testbench

- Downstream consumer of the 5-bit Gray counter output.
- Samples the Gray word on each enabled clock, converts it to binary, and checks that the sequence advances by exactly +1 (mod 2^WIDTH).
- Flags, counts and recovers from sequence errors.
- Used as the in-design monitor and decode stage for the Gray counter.

---
 rtl/gray_check.sv | 145 ++++++++++++++
 tb/tb_gray_check.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gray_check.sv
// rtl/gray_check.sv - Gray sequence decoder and +1 sequence monitor
//
// Purpose:
//   Samples a Gray-coded count on each enabled clock and decodes it to binary.
//   Checks that each sample advances by exactly +1 (mod 2^WIDTH) relative to
//   the previous one. Flags, counts and recovers from sequence errors.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset (priority over enable_in)
//   enable_in  in   sample qualifier
//   gray_in    in   [WIDTH-1:0] Gray-coded count from upstream
//   bin_out    out  [WIDTH-1:0] registered binary decode of last sample
//   bin_valid  out  one-cycle strobe after each accepted sample
//   seq_err    out  one-cycle pulse when a sample broke the +1 sequence
//   err_count  out  [ERR_CNT_W-1:0] saturating count of seq_err pulses
//   locked     out  high while tracking a valid sequence
//
// Build option:
//   GRAY_CHK_STICKY_EN - when defined, the error state is terminal until
//   reset: samples are still decoded but no further checking or counting.

module gray_check #(
  parameter int WIDTH     = 5,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_in,
  input  logic [WIDTH-1:0]     gray_in,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 locked
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     prev_bin_q, prev_bin_d;
  logic [WIDTH-1:0]     bin_out_q, bin_out_d;
  logic                 bin_valid_q, bin_valid_d;
  logic                 seq_err_q, seq_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0]     decode;
  logic [WIDTH-1:0]     expected;

  // Binary bit i is the XOR of all Gray bits at or above i; computing it as a
  // reduction avoids a bit-level self-dependency inside the vector.
  always_comb begin
    decode = '0;
    for (int i = 0; i < WIDTH; i++) begin
      decode[i] = ^(gray_in >> i);
    end
  end

  // Natural wrap of the WIDTH-bit add gives the mod 2^WIDTH successor.
  assign expected = prev_bin_q + {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    prev_bin_d  = prev_bin_q;
    bin_out_d   = bin_out_q;
    bin_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    err_count_d = err_count_q;

    case (state_q)
      SYNC: begin
        if (enable_in) begin
          prev_bin_d  = decode;
          bin_out_d   = decode;
          bin_valid_d = 1'b1;
          state_d     = TRACK;
        end
      end

      TRACK: begin
        if (enable_in) begin
          prev_bin_d  = decode;
          bin_out_d   = decode;
          bin_valid_d = 1'b1;
          if (decode != expected) begin
            seq_err_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
            state_d = ERROR;
          end
        end
      end

      ERROR: begin
        if (enable_in) begin
          bin_out_d   = decode;
          bin_valid_d = 1'b1;
`ifdef GRAY_CHK_STICKY_EN
          // Terminal until reset: keep decoding, never re-lock.
          state_d     = ERROR;
`else
          // Resync: accept this sample unchecked as the new reference.
          prev_bin_d  = decode;
          state_d     = TRACK;
`endif
        end
      end

      // Unused encoding recovers to SYNC regardless of enable_in.
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SYNC;
      prev_bin_q  <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_bin_q  <= prev_bin_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      seq_err_q   <= seq_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bin_out   = bin_out_q;
  assign bin_valid = bin_valid_q;
  assign seq_err   = seq_err_q;
  assign err_count = err_count_q;
  assign locked    = (state_q == TRACK);

endmodule

// File: tb/tb_gray_check.sv
// tb/tb_gray_check.sv - self-checking bench for gray_check
module tb_gray_check;

  localparam int WIDTH     = 5;
  localparam int ERR_CNT_W = 8;
  localparam int MODV      = 1 << WIDTH;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 clk;
  logic                 reset;
  logic                 enable_in;
  logic [WIDTH-1:0]     gray_in;
  logic [WIDTH-1:0]     bin_out;
  logic                 bin_valid;
  logic                 seq_err;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 locked;

  int vectors;
  int miscompares;

  // Reference model: what the monitor should report, in plain terms.
  int m_bin;
  int m_prev;
  int m_cnt;
  bit m_valid;
  bit m_err;
  bit m_synced;   // a reference value has been captured since reset
  bit m_broken;   // last check failed and no resync has happened yet

  gray_check #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable_in (enable_in),
    .gray_in   (gray_in),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .seq_err   (seq_err),
    .err_count (err_count),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int g2b(input int g);
    int b;
    b = 0;
    for (int s = g; s != 0; s = s >> 1) b = b ^ s;
    return b;
  endfunction

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_update(input bit rst, input bit en, input int g);
    int d;
    d = g2b(g);
    if (rst) begin
      m_bin = 0; m_prev = 0; m_cnt = 0;
      m_valid = 0; m_err = 0; m_synced = 0; m_broken = 0;
    end else if (!en) begin
      m_valid = 0; m_err = 0;
    end else begin
      m_valid = 1; m_err = 0; m_bin = d;
      if (!m_synced) begin
        m_prev = d; m_synced = 1; m_broken = 0;
      end else if (m_broken) begin
`ifndef GRAY_CHK_STICKY_EN
        m_prev = d; m_broken = 0;
`endif
      end else if (d == (m_prev + 1) % MODV) begin
        m_prev = d;
      end else begin
        m_prev = d; m_err = 1; m_broken = 1;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    bit exp_locked;
    exp_locked = m_synced && !m_broken;
    assert (bin_out === m_bin[WIDTH-1:0]) else begin
      miscompares++;
      $error("FAIL %s bin_out observed=%0d expected=%0d", tag, bin_out, m_bin);
    end
    assert (bin_valid === m_valid) else begin
      miscompares++;
      $error("FAIL %s bin_valid observed=%0b expected=%0b", tag, bin_valid, m_valid);
    end
    assert (seq_err === m_err) else begin
      miscompares++;
      $error("FAIL %s seq_err observed=%0b expected=%0b", tag, seq_err, m_err);
    end
    assert (err_count === m_cnt[ERR_CNT_W-1:0]) else begin
      miscompares++;
      $error("FAIL %s err_count observed=%0d expected=%0d", tag, err_count, m_cnt);
    end
    assert (locked === exp_locked) else begin
      miscompares++;
      $error("FAIL %s locked observed=%0b expected=%0b", tag, locked, exp_locked);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then check 1 ns later.
  task automatic step(input string tag, input bit rst, input bit en, input int g);
    reset     = rst;
    enable_in = en;
    gray_in   = g[WIDTH-1:0];
    @(posedge clk);
    model_update(rst, en, g);
    #1;
    check_outputs(tag);
    vectors++;
  endtask

  initial begin
    int g;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    enable_in   = 1'b0;
    gray_in     = '0;

    // Reset for two clocks, even with enable asserted.
    step("reset0", 1, 0, 0);
    step("reset1", 1, 1, 5);

    // Short in-order run: Gray 0,1,3,2,6 -> binary 0..4.
    step("basic0", 0, 1, 0);
    step("basic1", 0, 1, 1);
    step("basic2", 0, 1, 3);
    step("basic3", 0, 1, 2);
    step("basic4", 0, 1, 6);

    // Full range with wrap 31 -> 0.
    step("wrap_rst", 1, 0, 0);
    for (int i = 0; i <= MODV; i++) step("wrap", 0, 1, b2g(i % MODV));

    // Walk to binary 5, then a backwards sample, resync, and re-lock.
    for (int i = 1; i <= 5; i++) step("walk", 0, 1, b2g(i));
    step("bad_back", 0, 1, 5'b00110);
    step("resync",   0, 1, 5'b00010);
    step("relock",   0, 1, 5'b00110);

    // Enable low for three clocks while gray_in wanders.
    for (int i = 0; i < 3; i++) step("hold", 0, 0, $urandom_range(0, MODV - 1));
    step("resume", 0, 1, b2g(5));

    // Saturation: alternate Gray 0 / Gray 3 long enough for >255 errors.
    step("sat_rst", 1, 0, 0);
    for (int i = 0; i < 540; i++) step("sat", 0, 1, (i % 2 == 0) ? 0 : 3);

    // Reset while in the error state with a small count.
    step("err7_rst", 1, 0, 0);
    step("err7_sync", 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      step("err7_bad", 0, 1, 3);
      if (i < 6) step("err7_re", 0, 1, 0);
    end
    step("err7_reset", 1, 1, 3);

    // Error case again; second bad sample behaves per build option.
    step("two_sync", 0, 1, 0);
    step("two_ok",   0, 1, 1);
    step("two_bad1", 0, 1, 0);
    step("two_bad2", 0, 1, 5);
    step("two_next", 0, 1, b2g(7));

    // Randomized mix biased toward legal successors.
    step("rand_rst", 1, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 7) g = b2g((m_prev + 1) % MODV);
      else g = $urandom_range(0, MODV - 1);
      step("rand", ($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0), g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
